// File: rtl/pr_softreg_regfile_pkg.sv
// ---------------------------------------------------------------------------
// pr_softreg_regfile_pkg
// Register map and state encoding shared by the PageRank SoftReg responder
// and anything that talks to it.
//   - ADDR_*        : SoftReg register addresses. The seven configuration
//                     registers occupy addresses 0..NUM_CFG-1, so a cfg
//                     address doubles as its index into the cfg array.
//   - state_e       : responder state (CONFIG, RUNNING, DONE).
// ---------------------------------------------------------------------------
package pr_softreg_regfile_pkg;

    localparam int unsigned NUM_CFG = 7;

    // Configuration registers (index == address)
    localparam int unsigned ADDR_N_VERT           = 0;
    localparam int unsigned ADDR_N_INEDGES        = 1;
    localparam int unsigned ADDR_VADDR            = 2;
    localparam int unsigned ADDR_IEADDR           = 3;
    localparam int unsigned ADDR_WRITE_ADDR0      = 4;
    localparam int unsigned ADDR_WRITE_ADDR1      = 5;
    localparam int unsigned ADDR_N_ROUNDS         = 6;
    // Control / status registers
    localparam int unsigned ADDR_DO_INIT          = 7;
    localparam int unsigned ADDR_DONE_READ_PARAMS = 8;
    localparam int unsigned ADDR_STATUS           = 9;
    localparam int unsigned ADDR_CYCLE_CNT        = 10;

    typedef enum logic [1:0] {
        ST_CONFIG  = 2'd0,
        ST_RUNNING = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

endpackage

// File: rtl/pr_softreg_regfile.sv
// ---------------------------------------------------------------------------
// pr_softreg_regfile
// SoftReg responder for the PageRank accelerator. Host writes land in the
// configuration registers, a DONE_READ_PARAMS write launches the core with a
// one-cycle start pulse, reads are answered with latency 1, and the core's
// completion status is returned as an unsolicited response.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   softreg_req_*               host request (valid, isWrite, addr, data)
//   softreg_resp_valid/_data    one-cycle response strobe and payload
//   cfg_*                       latched configuration towards the core
//   cfg_do_init                 bit 0 of the last DO_INIT write
//   core_start                  one-cycle start pulse to the core
//   core_done, core_status      completion pulse and status from the core
// ---------------------------------------------------------------------------
module pr_softreg_regfile
    import pr_softreg_regfile_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              softreg_req_valid,
    input  logic              softreg_req_isWrite,
    input  logic [ADDR_W-1:0] softreg_req_addr,
    input  logic [DATA_W-1:0] softreg_req_data,
    output logic              softreg_resp_valid,
    output logic [DATA_W-1:0] softreg_resp_data,
    output logic [DATA_W-1:0] cfg_n_vert,
    output logic [DATA_W-1:0] cfg_n_inedges,
    output logic [DATA_W-1:0] cfg_vaddr,
    output logic [DATA_W-1:0] cfg_ieaddr,
    output logic [DATA_W-1:0] cfg_waddr0,
    output logic [DATA_W-1:0] cfg_waddr1,
    output logic [DATA_W-1:0] cfg_n_rounds,
    output logic              cfg_do_init,
    output logic              core_start,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_status
);

    logic [DATA_W-1:0] cfg_q [NUM_CFG];
    logic              do_init_q;
    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] status_q;
    logic              start_q;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    // One-deep holding slots for a response that lost arbitration
    logic              rd_pend_q, rd_pend_d;
    logic [DATA_W-1:0] rd_pend_data_q, rd_pend_data_d;
    logic              cmp_pend_q, cmp_pend_d;

    logic              wr_en, rd_en, cmp_en, drp_wr;
    logic [DATA_W-1:0] rd_data;

    // Writes are only honoured outside a run so the core sees stable config
    assign wr_en  = softreg_req_valid && softreg_req_isWrite && (state_q != ST_RUNNING);
    assign rd_en  = softreg_req_valid && !softreg_req_isWrite;
    assign cmp_en = core_done && (state_q == ST_RUNNING);
    assign drp_wr = wr_en && (softreg_req_addr == ADDR_W'(ADDR_DONE_READ_PARAMS));

    // Read data mux; unknown addresses return 0
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_CFG; i++) begin
            if (softreg_req_addr == ADDR_W'(i)) rd_data = cfg_q[i];
        end
        if (softreg_req_addr == ADDR_W'(ADDR_DO_INIT))   rd_data = DATA_W'(do_init_q);
        if (softreg_req_addr == ADDR_W'(ADDR_STATUS))    rd_data = status_q;
        if (softreg_req_addr == ADDR_W'(ADDR_CYCLE_CNT)) rd_data = DATA_W'(cnt_q);
    end

    // Response arbitration: a held response is oldest and goes first, then a
    // fresh read, then a fresh completion. Whatever loses waits one cycle in
    // its slot. At most one response is ever waiting because a completion can
    // only occur once per run and a write cycle (needed to restart) drains it.
    always_comb begin
        logic busy;
        busy           = 1'b0;
        resp_valid_d   = 1'b0;
        resp_data_d    = '0;
        rd_pend_d      = 1'b0;
        rd_pend_data_d = rd_pend_data_q;
        cmp_pend_d     = 1'b0;
        if (rd_pend_q) begin
            resp_valid_d = 1'b1;
            resp_data_d  = rd_pend_data_q;
            busy         = 1'b1;
        end
        if (cmp_pend_q) begin
            if (!busy) begin
                resp_valid_d = 1'b1;
                resp_data_d  = status_q;
                busy         = 1'b1;
            end else begin
                cmp_pend_d = 1'b1;
            end
        end
        if (rd_en) begin
            if (!busy) begin
                resp_valid_d = 1'b1;
                resp_data_d  = rd_data;
                busy         = 1'b1;
            end else begin
                rd_pend_d      = 1'b1;
                rd_pend_data_d = rd_data;
            end
        end
        if (cmp_en) begin
            if (!busy) begin
                resp_valid_d = 1'b1;
                resp_data_d  = core_status;
            end else begin
                cmp_pend_d = 1'b1;
            end
        end
    end

    // Run counter: cleared on launch, counts running cycles up to (not
    // including) the completion cycle, saturates instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (drp_wr) begin
            cnt_d = '0;
        end else if ((state_q == ST_RUNNING) && !core_done && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= '0;
            do_init_q      <= 1'b0;
            state_q        <= ST_CONFIG;
            cnt_q          <= '0;
            status_q       <= '0;
            start_q        <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_data_q    <= '0;
            rd_pend_q      <= 1'b0;
            rd_pend_data_q <= '0;
            cmp_pend_q     <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            start_q        <= drp_wr;
            resp_valid_q   <= resp_valid_d;
            resp_data_q    <= resp_data_d;
            rd_pend_q      <= rd_pend_d;
            rd_pend_data_q <= rd_pend_data_d;
            cmp_pend_q     <= cmp_pend_d;
            if (wr_en) begin
                for (int i = 0; i < NUM_CFG; i++) begin
                    if (softreg_req_addr == ADDR_W'(i)) cfg_q[i] <= softreg_req_data;
                end
                if (softreg_req_addr == ADDR_W'(ADDR_DO_INIT)) do_init_q <= softreg_req_data[0];
            end
            if (cmp_en) status_q <= core_status;
            case (state_q)
                ST_CONFIG:  if (drp_wr) state_q <= ST_RUNNING;
                ST_RUNNING: if (core_done) state_q <= ST_DONE;
                ST_DONE:    if (drp_wr) state_q <= ST_RUNNING;
                default:    state_q <= ST_CONFIG;
            endcase
        end
    end

    assign softreg_resp_valid = resp_valid_q;
    assign softreg_resp_data  = resp_data_q;
    assign cfg_n_vert         = cfg_q[ADDR_N_VERT];
    assign cfg_n_inedges      = cfg_q[ADDR_N_INEDGES];
    assign cfg_vaddr          = cfg_q[ADDR_VADDR];
    assign cfg_ieaddr         = cfg_q[ADDR_IEADDR];
    assign cfg_waddr0         = cfg_q[ADDR_WRITE_ADDR0];
    assign cfg_waddr1         = cfg_q[ADDR_WRITE_ADDR1];
    assign cfg_n_rounds       = cfg_q[ADDR_N_ROUNDS];
    assign cfg_do_init        = do_init_q;
    assign core_start         = start_q;

endmodule

// File: tb/tb_pr_softreg_regfile.sv
// ---------------------------------------------------------------------------
// tb_pr_softreg_regfile
// Drives host requests and core completions, keeps a reference model of the
// register file and an ordered response queue, and compares every response
// (data and arrival cycle) plus the cfg/start outputs after every cycle.
// ---------------------------------------------------------------------------
module tb_pr_softreg_regfile;
    import pr_softreg_regfile_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int CNT_W  = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_wr = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_data = '0;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic [DATA_W-1:0] c_nv, c_ne, c_va, c_ie, c_w0, c_w1, c_nr;
    logic              c_init, c_start;
    logic              done = 1'b0;
    logic [DATA_W-1:0] status = '0;

    always #5 clk = ~clk;

    pr_softreg_regfile #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .softreg_req_valid   (req_valid),
        .softreg_req_isWrite (req_wr),
        .softreg_req_addr    (req_addr),
        .softreg_req_data    (req_data),
        .softreg_resp_valid  (resp_valid),
        .softreg_resp_data   (resp_data),
        .cfg_n_vert          (c_nv),
        .cfg_n_inedges       (c_ne),
        .cfg_vaddr           (c_va),
        .cfg_ieaddr          (c_ie),
        .cfg_waddr0          (c_w0),
        .cfg_waddr1          (c_w1),
        .cfg_n_rounds        (c_nr),
        .cfg_do_init         (c_init),
        .core_start          (c_start),
        .core_done           (done),
        .core_status         (status)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [63:0] data;
    } exp_t;

    exp_t        sb[$];      // expected responses with the cycle they must appear
    logic [63:0] mq[$];      // model: responses waiting for the single output slot

    // Reference model (state: 0 idle/config, 1 running, 2 done)
    logic [63:0]     m_cfg [7];
    logic            m_init;
    int              m_state;
    longint unsigned m_cnt;
    logic [63:0]     m_status;
    logic            m_start;

    function automatic logic [63:0] m_read(input int unsigned a);
        if (a < 7)                   return m_cfg[a];
        if (a == ADDR_DO_INIT)       return {63'd0, m_init};
        if (a == ADDR_STATUS)        return m_status;
        if (a == ADDR_CYCLE_CNT)     return m_cnt;
        return 64'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 7; i++) m_cfg[i] = '0;
        m_init   = 1'b0;
        m_state  = 0;
        m_cnt    = 0;
        m_status = '0;
        m_start  = 1'b0;
        mq.delete();
        sb.delete();
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_outputs();
        check("cfg_n_vert",    c_nv, m_cfg[ADDR_N_VERT]);
        check("cfg_n_inedges", c_ne, m_cfg[ADDR_N_INEDGES]);
        check("cfg_vaddr",     c_va, m_cfg[ADDR_VADDR]);
        check("cfg_ieaddr",    c_ie, m_cfg[ADDR_IEADDR]);
        check("cfg_waddr0",    c_w0, m_cfg[ADDR_WRITE_ADDR0]);
        check("cfg_waddr1",    c_w1, m_cfg[ADDR_WRITE_ADDR1]);
        check("cfg_n_rounds",  c_nr, m_cfg[ADDR_N_ROUNDS]);
        check("cfg_do_init",   {63'd0, c_init},  {63'd0, m_init});
        check("core_start",    {63'd0, c_start}, {63'd0, m_start});
    endtask

    // One clock cycle of stimulus; the model advances using pre-edge state
    task automatic step(input logic v, input logic w, input int unsigned a,
                        input logic [63:0] d, input logic dn, input logic [63:0] st);
        logic done_acc;
        req_valid = v;
        req_wr    = w;
        req_addr  = ADDR_W'(a);
        req_data  = d;
        done      = dn;
        status    = st;
        m_start   = 1'b0;
        done_acc  = dn && (m_state == 1);
        if (v && !w) mq.push_back(m_read(a));
        if (done_acc) begin
            mq.push_back(st);
            m_status = st;
        end
        if (m_state == 1 && !dn && m_cnt != 64'hFFFF_FFFF_FFFF_FFFF) m_cnt++;
        if (done_acc) begin
            m_state = 2;
        end else if (v && w && m_state != 1) begin
            if (a < 7)                         m_cfg[a] = d;
            else if (a == ADDR_DO_INIT)        m_init = d[0];
            else if (a == ADDR_DONE_READ_PARAMS) begin
                m_state = 1;
                m_cnt   = 0;
                m_start = 1'b1;
            end
        end
        if (mq.size() > 0) sb.push_back('{cyc + 1, mq.pop_front()});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        done      = 1'b0;
        check_outputs();
    endtask

    task automatic wr(input int unsigned a, input logic [63:0] d);
        step(1'b1, 1'b1, a, d, 1'b0, 64'd0);
    endtask
    task automatic rd(input int unsigned a);
        step(1'b1, 1'b0, a, 64'd0, 1'b0, 64'd0);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 64'd0, 1'b0, 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_outputs();
        check("reset_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("reset_resp_data",  resp_data, 64'd0);
        rst = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response
    always @(negedge clk) begin
        if (!rst) begin
            if (resp_valid) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL resp_unexpected cyc=%0d: got data %0h expected no response", cyc, resp_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.due != cyc || resp_data !== e.data) begin
                        miscompares++;
                        $display("FAIL resp cyc=%0d: got data %0h expected data %0h at cyc %0d",
                                 cyc, resp_data, e.data, e.due);
                    end
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL resp_missing cyc=%0d: got no response expected data %0h", cyc, sb[0].data);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        do_reset();

        // Configuration writes, one per cycle, no responses expected
        wr(ADDR_N_VERT, 64'd1001);
        wr(ADDR_VADDR, 64'd0);
        wr(ADDR_IEADDR, 64'd16064);
        wr(ADDR_N_ROUNDS, 64'd10);
        wr(ADDR_DO_INIT, 64'd3);
        wr(ADDR_WRITE_ADDR0, 64'hA5A5_0000_1234_5678);
        idle(2);

        // Back-to-back reads over the whole map including unknown addresses
        for (int a = 0; a < 13; a++) rd(a);
        rd(32'hFFFF_FFF0);
        wr(12, 64'hDEAD_BEEF_DEAD_BEEF);
        idle(2);

        // Launch, ignored write during run, 20 running cycles, completion
        wr(ADDR_DONE_READ_PARAMS, 64'd1);
        wr(ADDR_N_VERT, 64'd5);
        idle(19);
        step(1'b0, 1'b0, 0, 64'd0, 1'b1, 64'd1);
        idle(1);
        rd(ADDR_CYCLE_CNT);
        idle(2);

        // Read colliding with completion, followed by reads queued behind it
        wr(ADDR_DONE_READ_PARAMS, 64'd1);
        idle(5);
        step(1'b1, 1'b0, ADDR_STATUS, 64'd0, 1'b1, 64'd1);
        rd(ADDR_N_VERT);
        rd(ADDR_CYCLE_CNT);
        idle(3);
        step(1'b0, 1'b0, 0, 64'd0, 1'b1, 64'd7);   // done outside RUNNING: ignored
        rd(ADDR_STATUS);
        idle(2);

        // Reset with a completion pending, then a clean restart
        wr(ADDR_DONE_READ_PARAMS, 64'd1);
        idle(3);
        step(1'b1, 1'b0, ADDR_STATUS, 64'd0, 1'b1, 64'h55);
        do_reset();
        idle(3);
        wr(ADDR_DONE_READ_PARAMS, 64'd1);
        idle(4);
        step(1'b0, 1'b0, 0, 64'd0, 1'b1, 64'd1);
        rd(ADDR_STATUS);
        rd(ADDR_CYCLE_CNT);
        idle(2);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            int unsigned kind, a;
            logic [63:0] d, st;
            logic        dn;
            kind = $urandom_range(0, 9);
            a    = $urandom_range(0, 12);
            d    = {$urandom, $urandom};
            st   = {$urandom, $urandom};
            dn   = ($urandom_range(0, 7) == 0);
            if (kind < 4)       step(1'b1, 1'b0, a, d, dn, st);
            else if (kind < 7)  step(1'b1, 1'b1, a, d, dn, st);
            else if (kind == 7) step(1'b1, 1'b1, ADDR_DONE_READ_PARAMS, d, dn, st);
            else                step(1'b0, 1'b0, a, d, dn, st);
        end

        idle(4);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
